// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational lookup in
// Fetch, training, mispredict detection and statistics in Execute.
module branch_predictor #(
  parameter int WIDTH     = 32,
  parameter int ENTRIES   = 16,
  parameter int TAG_BITS  = 10,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     PCF,
  output logic                 PredTakenF,
  output logic [WIDTH-1:0]     PredTargetF,
  input  logic                 UpdateE,
  input  logic                 JumpE,
  input  logic [WIDTH-1:0]     PCE,
  input  logic                 TakenE,
  input  logic [WIDTH-1:0]     TargetE,
  input  logic                 PredTakenE,
  input  logic [WIDTH-1:0]     PredTargetE,
  output logic                 MispredictE,
  output logic [WIDTH-1:0]     RedirectPCE,
  input  logic                 FlushAll,
  input  logic                 ClearStats,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredCount
);

  localparam int IDX    = $clog2(ENTRIES);
  localparam int TAG_LO = IDX + 2;
  localparam int TAG_HI = TAG_LO + TAG_BITS - 1;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [WIDTH-1:0]    target_q [ENTRIES];
  logic [WIDTH-1:0]    target_d [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];

  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispred_count_q, mispred_count_d;

  logic [IDX-1:0]      idx_f, idx_e;
  logic [TAG_BITS-1:0] tag_f, tag_e;
  logic                hit_f, hit_e;

  assign idx_f = PCF[IDX+1:2];
  assign tag_f = PCF[TAG_HI:TAG_LO];
  assign idx_e = PCE[IDX+1:2];
  assign tag_e = PCE[TAG_HI:TAG_LO];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  // Lookup reads only registered state, so a same-cycle update is not seen.
  assign PredTakenF  = hit_f && ctr_q[idx_f][1];
  assign PredTargetF = PredTakenF ? target_q[idx_f] : PCF + WIDTH'(4);

  assign MispredictE = UpdateE &&
                       ((TakenE != PredTakenE) || (TakenE && (TargetE != PredTargetE)));
  assign RedirectPCE = TakenE ? TargetE : PCE + WIDTH'(4);

  assign BranchCount  = branch_count_q;
  assign MispredCount = mispred_count_q;

  // NOTE: every always_comb output gets a full default first so no path
  // leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (FlushAll) begin
      valid_d = '0;
    end else if (UpdateE) begin
      if (hit_e) begin
        if (JumpE) begin
          ctr_d[idx_e] = 2'd3;
        end else if (TakenE) begin
          if (ctr_q[idx_e] != 2'd3) ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
        end else begin
          if (ctr_q[idx_e] != 2'd0) ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
        end
        if (TakenE) target_d[idx_e] = TargetE;
      end else if (TakenE) begin
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = TargetE;
        ctr_d[idx_e]    = JumpE ? 2'd3 : 2'd2;
      end
    end
  end

  always_comb begin
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (ClearStats) begin
      branch_count_d  = '0;
      mispred_count_d = '0;
    end else begin
      if (UpdateE)     branch_count_d  = branch_count_q + CNT_WIDTH'(1);
      if (MispredictE) mispred_count_d = mispred_count_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: the BTB arrays are reset along with the valid bits because their
  // post-reset contents (weakly-not-taken counters, zero targets) are defined
  // behaviour; this keeps them in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      target_q        <= target_d;
      ctr_q           <= ctr_d;
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed corner cases, a vector
// table for the EXE redirect logic, and randomized traffic against a model.
module tb_branch_predictor;

  localparam int WIDTH    = 32;
  localparam int ENTRIES  = 16;
  localparam int TAG_BITS = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  PCF;
  logic              PredTakenF;
  logic [WIDTH-1:0]  PredTargetF;
  logic              UpdateE, JumpE, TakenE, PredTakenE;
  logic [WIDTH-1:0]  PCE, TargetE, PredTargetE;
  logic              MispredictE;
  logic [WIDTH-1:0]  RedirectPCE;
  logic              FlushAll, ClearStats;
  logic [31:0]       BranchCount, MispredCount;

  branch_predictor #(
    .WIDTH(WIDTH), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .UpdateE(UpdateE), .JumpE(JumpE), .PCE(PCE),
    .TakenE(TakenE), .TargetE(TargetE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .MispredictE(MispredictE),
    .RedirectPCE(RedirectPCE), .FlushAll(FlushAll), .ClearStats(ClearStats),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a table of entries keyed by word index, plain integers.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_branches, m_mispreds;

  function automatic int unsigned slot_of(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_BITS);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[slot_of(pc)] && m_tag[slot_of(pc)] == tag_of(pc);
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output logic tk,
                                       output logic [31:0] tgt);
    tk  = model_hit(pc) && m_ctr[slot_of(pc)] >= 2;
    tgt = tk ? m_target[slot_of(pc)] : pc + 32'd4;
  endfunction

  // The fetch went wrong if direction differs or the next PC differs.
  function automatic logic model_mispredict();
    logic [31:0] actual_next, predicted_next;
    actual_next    = TakenE ? TargetE : PCE + 32'd4;
    predicted_next = PredTakenE ? PredTargetE : PCE + 32'd4;
    return UpdateE && (TakenE != PredTakenE || actual_next != predicted_next);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1;
    end
    m_branches = '0;
    m_mispreds = '0;
  endfunction

  function automatic void model_apply();
    int unsigned s;
    logic mis;
    s   = slot_of(PCE);
    mis = model_mispredict();
    if (FlushAll) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    end else if (UpdateE) begin
      if (model_hit(PCE)) begin
        if (JumpE)       m_ctr[s] = 3;
        else if (TakenE) m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
        else             m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        if (TakenE) m_target[s] = TargetE;
      end else if (TakenE) begin
        m_valid[s]  = 1;
        m_tag[s]    = tag_of(PCE);
        m_target[s] = TargetE;
        m_ctr[s]    = JumpE ? 3 : 2;
      end
    end
    if (ClearStats) begin
      m_branches = '0;
      m_mispreds = '0;
    end else begin
      if (UpdateE) m_branches = m_branches + 32'd1;
      if (mis)     m_mispreds = m_mispreds + 32'd1;
    end
  endfunction

  task automatic step();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    UpdateE = 0; JumpE = 0; TakenE = 0; PredTakenE = 0;
    FlushAll = 0; ClearStats = 0;
  endtask

  task automatic set_upd(input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                         input logic jmp, input logic pt, input logic [31:0] ptgt);
    UpdateE = 1; PCE = pce; TakenE = tk; TargetE = tgt; JumpE = jmp;
    PredTakenE = pt; PredTargetE = ptgt;
  endtask

  task automatic expect_pred(input string name, input logic [31:0] pc,
                             input logic tk, input logic [31:0] tgt);
    PCF = pc;
    #1;
    check({name, "_taken"}, PredTakenF, tk);
    check({name, "_target"}, PredTargetF, tgt);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = 32'($urandom_range(0, 63)) << 2;
    if ($urandom % 4 == 0) p = p | (32'($urandom_range(1, 255)) << 16);
    return p;
  endfunction

  typedef struct {
    logic        upd, jump, taken, pt;
    logic [31:0] pce, target, ptarget;
    logic        exp_mis;
    logic [31:0] exp_redirect;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1, 0, 1, 1, 32'h100, 32'h80,  32'h80,  0, 32'h80};
    vecs[1] = '{1, 0, 0, 1, 32'h100, 32'h80,  32'h80,  1, 32'h104};
    vecs[2] = '{1, 0, 0, 0, 32'h1fc, 32'h0,   32'h200, 0, 32'h200};
    vecs[3] = '{1, 0, 1, 1, 32'h100, 32'h90,  32'h80,  1, 32'h90};
    vecs[4] = '{0, 0, 1, 0, 32'h100, 32'h90,  32'h0,   0, 32'h90};
    vecs[5] = '{1, 1, 1, 0, 32'h200, 32'h400, 32'h204, 1, 32'h400};
    vecs[6] = '{1, 0, 0, 0, 32'hfffffffc, 32'h0, 32'h0, 0, 32'h0};
    vecs[7] = '{1, 0, 1, 1, 32'h300, 32'h300, 32'h304, 1, 32'h300};

    // Reset state
    rst = 0;
    idle();
    PCE = '0; TargetE = '0; PredTargetE = '0;
    model_reset();
    expect_pred("reset_lookup", 32'h100, 0, 32'h104);
    check("reset_branch_count", BranchCount, 0);
    check("reset_mispred_count", MispredCount, 0);
    @(negedge clk);
    rst = 1;

    // First taken branch allocates
    set_upd(32'h100, 1, 32'h80, 0, 0, 32'h104);
    #1;
    check("alloc_mispredict", MispredictE, 1);
    check("alloc_redirect", RedirectPCE, 32'h80);
    step();
    idle();
    expect_pred("alloc_lookup", 32'h100, 1, 32'h80);
    check("alloc_branch_count", BranchCount, 1);
    check("alloc_mispred_count", MispredCount, 1);

    // Saturation and hysteresis
    set_upd(32'h100, 1, 32'h80, 0, 1, 32'h80); step();
    set_upd(32'h100, 1, 32'h80, 0, 1, 32'h80); step();
    set_upd(32'h100, 0, 32'h80, 0, 1, 32'h80); step();
    idle();
    expect_pred("hyst_still_taken", 32'h100, 1, 32'h80);
    set_upd(32'h100, 0, 32'h80, 0, 1, 32'h80); step();
    idle();
    expect_pred("hyst_not_taken", 32'h100, 0, 32'h104);

    // Alias: same index, different tag overwrites
    set_upd(32'h100, 1, 32'h80, 0, 0, 32'h104); step();
    idle();
    expect_pred("alias_before", 32'h100, 1, 32'h80);
    set_upd(32'h140, 1, 32'h300, 0, 0, 32'h144); step();
    idle();
    expect_pred("alias_old_miss", 32'h100, 0, 32'h104);
    expect_pred("alias_new_hit", 32'h140, 1, 32'h300);

    // Jump allocates strongly taken; survives one not-taken
    set_upd(32'h200, 1, 32'h400, 1, 0, 32'h204); step();
    idle();
    expect_pred("jal_lookup", 32'h200, 1, 32'h400);
    set_upd(32'h200, 0, 32'h0, 0, 1, 32'h400); step();
    idle();
    expect_pred("jal_strong", 32'h200, 1, 32'h400);

    // Flush beats same-cycle allocation; lookup sees pre-update state
    set_upd(32'h244, 1, 32'h500, 0, 0, 32'h248);
    FlushAll = 1;
    expect_pred("flush_same_cycle", 32'h200, 1, 32'h400);
    step();
    idle();
    expect_pred("flush_miss_a", 32'h200, 0, 32'h204);
    expect_pred("flush_miss_b", 32'h244, 0, 32'h248);
    expect_pred("flush_miss_c", 32'h140, 0, 32'h144);

    // Target change on a taken branch
    set_upd(32'h100, 1, 32'h80, 0, 0, 32'h104); step();
    set_upd(32'h100, 1, 32'h90, 0, 1, 32'h80);
    #1;
    check("tchg_mispredict", MispredictE, 1);
    check("tchg_redirect", RedirectPCE, 32'h90);
    step();
    idle();
    expect_pred("tchg_lookup", 32'h100, 1, 32'h90);
    check("stats_branch_model", BranchCount, m_branches);
    check("stats_mispred_model", MispredCount, m_mispreds);

    // Clear wins over same-cycle increments
    set_upd(32'h100, 0, 32'h0, 0, 1, 32'h90);
    ClearStats = 1;
    step();
    idle();
    #1;
    check("clear_branch_count", BranchCount, 0);
    check("clear_mispred_count", MispredCount, 0);

    // Table of EXE redirect vectors
    for (int i = 0; i < 8; i++) begin
      idle();
      set_upd(vecs[i].pce, vecs[i].taken, vecs[i].target, vecs[i].jump,
              vecs[i].pt, vecs[i].ptarget);
      UpdateE = vecs[i].upd;
      #1;
      check($sformatf("vec%0d_mispredict", i), MispredictE, vecs[i].exp_mis);
      check($sformatf("vec%0d_redirect", i), RedirectPCE, vecs[i].exp_redirect);
      step();
    end
    idle();
    #1;
    check("vec_branch_count", BranchCount, m_branches);
    check("vec_mispred_count", MispredCount, m_mispreds);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        etk;
      logic [31:0] etgt;
      UpdateE = ($urandom % 4) != 0;
      PCE     = rand_pc();
      JumpE   = ($urandom % 5) == 0;
      TakenE  = JumpE ? 1'b1 : 1'($urandom % 2);
      TargetE = rand_pc();
      if ($urandom % 2) begin
        model_lookup(PCE, etk, etgt);
        PredTakenE = etk; PredTargetE = etgt;
      end else begin
        PredTakenE = 1'($urandom % 2); PredTargetE = rand_pc();
      end
      FlushAll   = ($urandom % 64) == 0;
      ClearStats = ($urandom % 64) == 0;
      PCF = rand_pc();
      #1;
      model_lookup(PCF, etk, etgt);
      check("rnd_pred_taken", PredTakenF, etk);
      check("rnd_pred_target", PredTargetF, etgt);
      check("rnd_mispredict", MispredictE, model_mispredict());
      check("rnd_redirect", RedirectPCE, TakenE ? TargetE : PCE + 32'd4);
      if (i == 1500) begin
        // Asynchronous reset in the middle of an update cycle
        #2;
        rst = 0;
        #1;
        model_reset();
        check("midrst_pred_taken", PredTakenF, 0);
        check("midrst_pred_target", PredTargetF, PCF + 32'd4);
        check("midrst_branch_count", BranchCount, 0);
        check("midrst_mispred_count", MispredCount, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
      end else begin
        step();
        check("rnd_branch_count", BranchCount, m_branches);
        check("rnd_mispred_count", MispredCount, m_mispreds);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
